// File: rtl/reload_arbiter.sv
// Shared self-reloading 4-bit counter. At each wrap (count==15) one pending
// requester is granted round-robin and its reload value is loaded into the counter.
module reload_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [4*NUM_REQ-1:0] load_val_i,
   output logic [NUM_REQ-1:0]   gnt_o,
   output logic [3:0]           count_o,
   output logic                 wrap_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [3:0]         count_q, count_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic [NUM_REQ-1:0] eligible;
   logic               found;
   logic [PTR_W-1:0]   win;
   logic [PTR_W-1:0]   idx_w;
   logic [3:0]         load_arr [NUM_REQ];
   int                 idx;
   int                 nxt;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign load_arr[k] = load_val_i[4*k+3:4*k];
   end

   // A requester whose grant is still visible is masked so a late drop of req cannot win twice.
   always_comb begin
      eligible = req_i & ~gnt_q;
      found    = 1'b0;
      win      = '0;
      idx      = 0;
      idx_w    = '0;
      nxt      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_w = PTR_W'(idx);
         if (!found && eligible[idx_w]) begin
            found = 1'b1;
            win   = idx_w;
         end
      end

      count_d  = count_q + 4'd1;
      gnt_d    = '0;
      rr_ptr_d = rr_ptr_q;
      if (count_q == 4'hf) begin
         if (found) begin
            count_d    = load_arr[win];
            gnt_d[win] = 1'b1;
            nxt        = int'(win) + 1;
            if (nxt >= NUM_REQ) nxt = 0;
            rr_ptr_d   = PTR_W'(nxt);
         end else begin
            count_d = 4'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q  <= 4'd0;
         gnt_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         gnt_q    <= gnt_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign gnt_o   = gnt_q;
   assign count_o = count_q;
   assign wrap_o  = (count_q == 4'hf);

endmodule

// File: tb/tb_reload_arbiter.sv
// Directed bench for reload_arbiter: inputs change and outputs are checked on the falling edge.
module tb_reload_arbiter;

   logic        clk;
   logic        reset_n;
   logic [3:0]  req_i;
   logic [15:0] load_val_i;
   logic [3:0]  gnt_o;
   logic [3:0]  count_o;
   logic        wrap_o;

   int n_checks = 0;
   int n_fail   = 0;

   reload_arbiter #(.NUM_REQ(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_i      (req_i),
      .load_val_i (load_val_i),
      .gnt_o      (gnt_o),
      .count_o    (count_o),
      .wrap_o     (wrap_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      req_i      = 4'b0;
      load_val_i = 16'h0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // Bounded wait until count_o==15 as seen on a falling edge.
   task automatic wait_wrap(input string name);
      int n = 0;
      while (count_o !== 4'hf && n < 20) begin
         tick();
         n++;
      end
      n_checks++;
      if (count_o !== 4'hf || wrap_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s wait_wrap: count_o=%h wrap_o=%b, expected count f wrap 1", name, count_o, wrap_o);
      end
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      req_i      = 4'b0;
      load_val_i = 16'h0;
      tick();
      n_checks++;
      if (count_o !== 4'd0 || gnt_o !== 4'b0 || wrap_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: count=%h gnt=%b wrap=%b, expected 0 0000 0", count_o, gnt_o, wrap_o);
      end
      reset_n = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         logic [3:0] exp_c;
         exp_c = 4'(i);
         tick();
         n_checks++;
         if (count_o !== exp_c || wrap_o !== (exp_c == 4'hf) || gnt_o !== 4'b0) begin
            n_fail++;
            $display("FAIL free_run[%0d]: count=%h wrap=%b gnt=%b, expected %h %b 0000",
                     i, count_o, wrap_o, gnt_o, exp_c, (exp_c == 4'hf));
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      req_i      = 4'b0100;
      load_val_i = 16'h0a00;
      wait_wrap("single");
      tick();
      n_checks++;
      if (gnt_o !== 4'b0100 || count_o !== 4'ha) begin
         n_fail++;
         $display("FAIL single_grant: gnt=%b count=%h, expected 0100 a", gnt_o, count_o);
      end
      req_i = 4'b0;
      tick();
      n_checks++;
      if (gnt_o !== 4'b0 || count_o !== 4'hb) begin
         n_fail++;
         $display("FAIL single_pulse: gnt=%b count=%h, expected 0000 b", gnt_o, count_o);
      end
      for (int i = 0; i < 4; i++) tick();
      n_checks++;
      if (count_o !== 4'hf || wrap_o !== 1'b1) begin
         n_fail++;
         $display("FAIL single_period: count=%h wrap=%b, expected f 1", count_o, wrap_o);
      end
      tick();
      n_checks++;
      if (count_o !== 4'h0 || gnt_o !== 4'b0) begin
         n_fail++;
         $display("FAIL single_noreq_reload: count=%h gnt=%b, expected 0 0000", count_o, gnt_o);
      end
   endtask

   task automatic test_contention();
      logic [3:0] exp_g [5];
      logic [3:0] exp_c [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_c = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd3};
      do_reset();
      req_i      = 4'b1111;
      load_val_i = 16'h9753;
      for (int r = 0; r < 5; r++) begin
         wait_wrap("contention");
         tick();
         n_checks++;
         if (gnt_o !== exp_g[r] || count_o !== exp_c[r]) begin
            n_fail++;
            $display("FAIL contention[%0d]: gnt=%b count=%h, expected %b %h",
                     r, gnt_o, count_o, exp_g[r], exp_c[r]);
         end
      end
      req_i = 4'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      req_i      = 4'b0011;
      load_val_i = 16'h002f;
      wait_wrap("b2b");
      tick();
      n_checks++;
      if (gnt_o !== 4'b0001 || count_o !== 4'hf || wrap_o !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first: gnt=%b count=%h wrap=%b, expected 0001 f 1", gnt_o, count_o, wrap_o);
      end
      // Requester 0 keeps req high one more cycle; the mask must exclude it.
      tick();
      n_checks++;
      if (gnt_o !== 4'b0010 || count_o !== 4'h2) begin
         n_fail++;
         $display("FAIL b2b_second: gnt=%b count=%h, expected 0010 2", gnt_o, count_o);
      end
      req_i = 4'b0;
      tick();
      n_checks++;
      if (gnt_o !== 4'b0 || count_o !== 4'h3) begin
         n_fail++;
         $display("FAIL b2b_after: gnt=%b count=%h, expected 0000 3", gnt_o, count_o);
      end
   endtask

   task automatic test_pointer_skip();
      do_reset();
      req_i      = 4'b0001;
      load_val_i = 16'h4004;
      wait_wrap("skip_pre");
      tick();
      req_i = 4'b0;
      n_checks++;
      if (gnt_o !== 4'b0001 || count_o !== 4'h4) begin
         n_fail++;
         $display("FAIL skip_pre_grant: gnt=%b count=%h, expected 0001 4", gnt_o, count_o);
      end
      req_i = 4'b1000;
      wait_wrap("skip");
      tick();
      n_checks++;
      if (gnt_o !== 4'b1000 || count_o !== 4'h4) begin
         n_fail++;
         $display("FAIL skip_grant3: gnt=%b count=%h, expected 1000 4", gnt_o, count_o);
      end
      // Pointer is now 0, so with 0 and 3 both pending, 0 must win.
      req_i = 4'b1001;
      wait_wrap("skip_post");
      tick();
      n_checks++;
      if (gnt_o !== 4'b0001 || count_o !== 4'h4) begin
         n_fail++;
         $display("FAIL skip_ptr_wrap: gnt=%b count=%h, expected 0001 4", gnt_o, count_o);
      end
      req_i = 4'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_i      = 4'b0010;
      load_val_i = 16'h0060;
      for (int i = 0; i < 7; i++) tick();
      n_checks++;
      if (count_o !== 4'h7) begin
         n_fail++;
         $display("FAIL mid_precount: count=%h, expected 7", count_o);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (count_o !== 4'h0 || gnt_o !== 4'b0 || wrap_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_async_clear: count=%h gnt=%b wrap=%b, expected 0 0000 0", count_o, gnt_o, wrap_o);
      end
      tick();
      reset_n = 1'b1;
      tick();
      n_checks++;
      if (count_o !== 4'h1) begin
         n_fail++;
         $display("FAIL mid_restart: count=%h, expected 1", count_o);
      end
      wait_wrap("mid");
      tick();
      n_checks++;
      if (gnt_o !== 4'b0010 || count_o !== 4'h6) begin
         n_fail++;
         $display("FAIL mid_grant: gnt=%b count=%h, expected 0010 6", gnt_o, count_o);
      end
      req_i = 4'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      req_i      = 4'b0;
      load_val_i = 16'h0;
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_pointer_skip();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reload_arbiter.md
# reload_arbiter

Shared self-reloading 4-bit counter with a round-robin reload scheduler. Up to NUM_REQ requesters each post a reload value. At every wrap point the block grants exactly one pending requester and reloads the counter with that requester's value; if none are pending, it reloads 0. It sits between the timer-client agents and the single counter resource, so clients never drive the counter directly.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_i  input  NUM_REQ  per-requester reload request. Level; held until granted.
- load_val_i  input  4*NUM_REQ  reload value. Requester k uses bits [4k+3:4k]; must be stable while req_i[k]=1.
- gnt_o  output  NUM_REQ  registered one-hot grant pulse. One cycle long.
- count_o  output  4  current counter value (registered).
- wrap_o  output  1  high while count_o==4'hf (decoded from the register).

## Operation
- State: count register (4b), gnt register (NUM_REQ b), round-robin pointer rr_ptr (clog2(NUM_REQ) b).
- Reset (reset_n=0, async): count=0, gnt_o=0, rr_ptr=0, wrap_o=0.
- count≠15: next count = count+1; next gnt = 0; rr_ptr holds.
- count==15 (wrap point):
  - eligible = req_i & ~gnt_o. A requester whose grant pulse is visible this cycle is masked.
  - Search eligible starting at index rr_ptr, ascending, wrapping modulo NUM_REQ. The first set bit wins (index w).
  - Winner found: next count = load_val_i[w]; next gnt = one-hot(w); rr_ptr <= (w+1) mod NUM_REQ.
  - No eligible request: next count = 0; next gnt = 0; rr_ptr holds.
- Requests are examined only at wrap points. Requests asserted and dropped between wraps are lost; that is legal and not an error.
- Requester protocol: on seeing gnt_o[k]=1, drop req_i[k] in that same cycle (combinationally) or on the next edge. The masking rule covers a requester that is one cycle late.
- Load value 15 is legal. The next cycle is again a wrap point, which gives back-to-back arbitration.
- All arithmetic is 4-bit modulo; the count 15→0 transition happens only via the no-request path.

## Timing
- Grant latency: gnt_o[w] and count_o==load_val_i[w] appear together, one clock after the cycle where count_o==15.
- gnt_o is never high for two consecutive cycles to the same requester.
- gnt_o is never multi-hot.
- wrap_o is a combinational decode of count_o with no extra delay.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge. Pending requests are not remembered; requesters keep req_i high and are served at the first wrap after release.
- Wrap period:
  - 16 cycles with no requests.
  - 16−v cycles after a reload with value v.
  - 1 cycle after a reload with value 15.

## Test plan
- Reset, no requests: count_o=0 during reset. After release, count_o steps 1..15, then 0, repeating. wrap_o is high only at 15. gnt_o stays 0.
- Single request: req_i[2]=1, load_val=4'ha, held. At the wrap: gnt_o=4'b0100 for one cycle, with count_o=10. Requester drops req_i. The next wrap, 5 cycles later, reloads 0.
- Contention: all four requests held with values 3,5,7,9; requesters never drop req. Successive grants go 0,1,2,3,0 and count_o after each wrap is 3,5,7,9,3.
- Back-to-back masking: req_i[0] with value 15, req_i[1] with value 2, req_0 late by one cycle. First wrap grants 0 (count_o=15). The next cycle's wrap masks 0 and grants 1 (count_o=2).
- Pointer skip: rr_ptr=1 (after a grant to 0), only req_i[3]=1. The grant goes to 3 and rr_ptr becomes 0.
- Reset mid-operation: assert reset_n=0 while count_o=7 and req_i=4'b0010. Outputs clear asynchronously. After release, counting restarts from 1 and requester 1 is granted at the first wrap.
